split_port_mem: RTL and testbench
=================================

// Module: split_port_mem
// PURPOSE
//  Clocked, parametrised successor to the combinational split-port memory.
//  One byte-addressable little-endian array with two independent ports:
//  - instruction port: read-only
//  - data port: read/write with byte enables
//  Each port has a req/valid handshake, a configurable read latency,
//  alignment/range/protection error reporting, and an optional post-reset clear
//  of the data region. Sits between the CPU core and the preloaded program image.
// PARAMETERS
//  MEM_BYTES      8192         total array size in bytes (power of 2)
//  ADDR_W         32           address port width
//  DATA_W         32           word width; fixed at 32 in this generation
//  INST_BASE      32'h1000     first byte of instruction region; data region is [0, INST_BASE)
//  RD_LAT         1            read latency in cycles, legal range 1..4
//  PROTECT_INST   1            1: data-port writes at addr >= INST_BASE are rejected with error
//  CLEAR_ON_RESET 0            1: after reset, zero the data region before accepting requests
//  INIT_FILE      "mem.hex"    $readmemh byte image loaded at time 0; "" = no load
// PORTS
//  clk      in   1       clock, all state updates on rising edge
//  rst      in   1       synchronous reset, active high
//  i_req    in   1       instruction fetch request
//  i_addr   in   ADDR_W  fetch byte address
//  i_ready  out  1       port accepting requests
//  i_valid  out  1       i_rdata/i_err valid this cycle
//  i_rdata  out  32      fetched word, 0 when i_valid=0 or i_err=1
//  i_err    out  1       fetch fault (misaligned / out of range), qualified by i_valid
//  d_req    in   1       data request
//  d_we     in   1       1 = write, 0 = read
//  d_be     in   4       byte enables; d_be[k] selects byte k of the word
//  d_addr   in   ADDR_W  data byte address
//  d_wdata  in   32      write data
//  d_ready  out  1       port accepting requests
//  d_valid  out  1       response valid (reads and writes both respond)
//  d_rdata  out  32      read word, 0 for writes, errors, or d_valid=0
//  d_err    out  1       fault, qualified by d_valid
// BEHAVIOUR
//  Reset
//  - All outputs reset to 0. Read pipelines are flushed, so in-flight responses
//    are dropped. Array contents are preserved.
//  FSM: RUN, CLEAR
//  - rst -> CLEAR if CLEAR_ON_RESET, else RUN.
//  - CLEAR:
//    - Counter walks word addresses 0..INST_BASE/4-1, one word of zeros per cycle.
//    - i_ready = d_ready = 0.
//    - Last word written -> RUN.
//    - rst during CLEAR restarts the counter at 0.
//  - RUN: i_ready = d_ready = 1.
//  Handshake
//  - A request is accepted when req & ready on a rising edge.
//  - One request per port per cycle; fully pipelined.
//  - Response appears with valid=1 exactly RD_LAT cycles after acceptance, for one cycle.
//  - Requests presented while ready=0 are ignored: no response, no side effect.
//  Errors (checked at acceptance; any error -> no array write, rdata=0, err=1)
//  - addr[1:0] != 0 (misaligned).
//  - addr > MEM_BYTES-4 (out of range).
//  - d_we & PROTECT_INST & addr >= INST_BASE (protected region).
//  Write
//  - Enabled bytes are committed at the acceptance edge.
//  - d_be = 0 is a legal no-op and still responds (valid=1, err=0).
//  Read
//  - Array is sampled at the acceptance edge.
//  - Data-port write then data-port read of the same word on the next cycle
//    returns the new data.
//  - Same-cycle data write and instruction read of the same word: the
//    instruction port returns the OLD word (read-before-write).
//  Byte order
//  - Little endian: word = {m[a+3], m[a+2], m[a+1], m[a]}.
// STRUCTURE
//  Shared package mem_pkg:
//  - Parameter defaults.
//  - FSM state enum {ST_RUN, ST_CLEAR}.
//  - Error-check function: (addr, we) -> err.
//  One sub-module, mem_rd_pipe:
//  - RD_LAT-deep shift register of {valid, err, rdata}.
//  - Synchronous flush on rst.
//  - Instantiated once per port.
//  Array, FSM and clear counter live in the top module.
// TESTING
//  1. Load image; fetch i_addr=0x1000, RD_LAT=1
//     -> next cycle i_valid=1, i_rdata equals the image word; RD_LAT=3 -> response on cycle 3.
//  2. Write d_addr=0x10, d_wdata=0xAABBCCDD, d_be=4'b0101 over a word holding 0x11223344
//     -> read returns 0x11BB33DD.
//  3. d_addr=0x0002 read; d_addr=0x2000 read; with PROTECT_INST=1, d_we=1 at 0x1004
//     -> each gives d_err=1, d_rdata=0, and 0x1004 is unchanged on fetch.
//  4. CLEAR_ON_RESET=1: preload data word at 0x0FFC, pulse rst
//     -> ready=0 for exactly INST_BASE/4 cycles, then 0x0FFC reads 0 and 0x1000 is intact.
//  5. Same cycle: data write 0x12345678 at 0x1008 (PROTECT_INST=0) plus fetch at 0x1008
//     -> fetch returns old word; a fetch on the next cycle returns 0x12345678.
//  6. Assert rst with RD_LAT=4 and 3 requests in flight
//     -> no valid pulses after reset; memory contents unchanged.

Source files
------------

// File: rtl/split_port_mem_pkg.sv
// mem_pkg: shared defaults, FSM states, response record and address fault check for split_port_mem
package mem_pkg;
    localparam int unsigned MEM_BYTES_DEF = 8192;
    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned INST_BASE_DEF = 32'h1000;
    localparam int unsigned RD_LAT_DEF = 1;
    localparam bit PROTECT_INST_DEF = 1'b1;
    localparam bit CLEAR_ON_RESET_DEF = 1'b0;
    localparam string INIT_FILE_DEF = "mem.hex";

    typedef enum logic {ST_RUN, ST_CLEAR} state_t;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    function automatic logic addr_err(input logic [63:0] addr, input logic we, input int unsigned mem_bytes,
                                      input int unsigned inst_base, input bit protect_inst);
        return addr[1:0] != 2'b00 || addr > 64'(mem_bytes - 4) || (we && protect_inst && addr >= 64'(inst_base));
    endfunction
endpackage

// File: rtl/split_port_mem_if.sv
// split_port_mem_if: fetch and data port signals of split_port_mem
interface split_port_mem_if #(
    parameter int ADDR_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ready;
    logic              i_valid;
    logic [31:0]       i_rdata;
    logic              i_err;
    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_ready;
    logic              d_valid;
    logic [31:0]       d_rdata;
    logic              d_err;

    modport master (
        output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
        input  i_ready, i_valid, i_rdata, i_err, d_ready, d_valid, d_rdata, d_err
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
        output i_ready, i_valid, i_rdata, i_err, d_ready, d_valid, d_rdata, d_err
    );
endinterface

// File: rtl/split_port_mem_rd_pipe.sv
// mem_rd_pipe: LAT-deep response delay line, flushed by synchronous reset
module mem_rd_pipe
    import mem_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  rsp_t rsp_in,
    output rsp_t rsp_out
);
    rsp_t stage [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) stage[i] <= '0;
        end else begin
            stage[0] <= rsp_in;
            for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
        end
    end

    assign rsp_out = stage[LAT-1];
endmodule

// File: rtl/split_port_mem.sv
// split_port_mem: byte-addressable little-endian memory with a read-only fetch port and a read/write data port
module split_port_mem
    import mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES      = MEM_BYTES_DEF,
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned INST_BASE      = INST_BASE_DEF,
    parameter int unsigned RD_LAT         = RD_LAT_DEF,
    parameter bit          PROTECT_INST   = PROTECT_INST_DEF,
    parameter bit          CLEAR_ON_RESET = CLEAR_ON_RESET_DEF,
    parameter string       INIT_FILE      = INIT_FILE_DEF
) (
    input logic             clk,
    input logic             rst,
    split_port_mem_if.slave bus
);
    localparam int MW = $clog2(MEM_BYTES);
    localparam int BPW = DATA_W / 8;
    localparam int CW = $clog2(INST_BASE / 4) + 1;
    localparam logic [CW-1:0] CLR_LAST = CW'(INST_BASE / 4 - 1);

    logic [7:0]    mem [MEM_BYTES];
    state_t        state, state_n;
    logic [CW-1:0] clr_cnt;
    logic          i_acc, d_acc, i_bad, d_bad;
    logic [31:0]   i_word, d_word;
    rsp_t          i_in, d_in, i_rsp, d_rsp;

    always_comb state_n = (state == ST_CLEAR && clr_cnt == CLR_LAST) ? ST_RUN : state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_cnt <= '0;
        end else begin
            state   <= state_n;
            clr_cnt <= (state == ST_CLEAR) ? clr_cnt + 1'b1 : '0;
        end
    end

    assign bus.i_ready = state == ST_RUN;
    assign bus.d_ready = state == ST_RUN;
    assign i_acc = bus.i_req & bus.i_ready & ~rst;
    assign d_acc = bus.d_req & bus.d_ready & ~rst;
    assign i_bad = addr_err({{(64 - ADDR_W){1'b0}}, bus.i_addr}, 1'b0, MEM_BYTES, INST_BASE, PROTECT_INST);
    assign d_bad = addr_err({{(64 - ADDR_W){1'b0}}, bus.d_addr}, bus.d_we, MEM_BYTES, INST_BASE, PROTECT_INST);

    always_comb begin
        i_word = '0;
        d_word = '0;
        for (int k = 0; k < BPW; k++) begin
            i_word[8*k +: 8] = mem[{bus.i_addr[MW-1:2], 2'(k)}];
            d_word[8*k +: 8] = mem[{bus.d_addr[MW-1:2], 2'(k)}];
        end
    end

    always_comb begin
        i_in = '{valid: i_acc, err: i_acc & i_bad, rdata: (i_acc & ~i_bad) ? i_word : '0};
        d_in = '{valid: d_acc, err: d_acc & d_bad, rdata: (d_acc & ~d_bad & ~bus.d_we) ? d_word : '0};
    end

    always_ff @(posedge clk) begin
        if (!rst && state == ST_CLEAR) begin
            for (int k = 0; k < BPW; k++) mem[MW'({clr_cnt, 2'(k)})] <= '0;
        end else if (d_acc && bus.d_we && !d_bad) begin
            for (int k = 0; k < BPW; k++) if (bus.d_be[k]) mem[{bus.d_addr[MW-1:2], 2'(k)}] <= bus.d_wdata[8*k +: 8];
        end
    end

    mem_rd_pipe #(.LAT(RD_LAT)) u_i_pipe (.clk(clk), .rst(rst), .rsp_in(i_in), .rsp_out(i_rsp));
    mem_rd_pipe #(.LAT(RD_LAT)) u_d_pipe (.clk(clk), .rst(rst), .rsp_in(d_in), .rsp_out(d_rsp));

    assign bus.i_valid = i_rsp.valid;
    assign bus.i_err   = i_rsp.err;
    assign bus.i_rdata = i_rsp.rdata;
    assign bus.d_valid = d_rsp.valid;
    assign bus.d_err   = d_rsp.err;
    assign bus.d_rdata = d_rsp.rdata;
endmodule

// File: tb/tb_split_port_mem.sv
// tb_split_port_mem: three configurations of split_port_mem driven by directed vectors,
// responses checked by a scoreboard monitor that also enforces exact latency
module tb_split_port_mem;
    localparam int LAT [3] = '{1, 3, 4};
    localparam bit PROT [3] = '{1'b1, 1'b0, 1'b1};
    localparam bit CLR [3] = '{1'b0, 1'b1, 1'b0};

    typedef struct {
        int          port;
        int          due;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic [2:0]  rst;
    logic [2:0]  i_req, i_ready, i_valid, i_err, d_req, d_we, d_ready, d_valid, d_err;
    logic [31:0] i_addr [3], i_rdata [3], d_addr [3], d_wdata [3], d_rdata [3];
    logic [3:0]  d_be [3];
    exp_t        sb [$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_on = 1'b0;
    logic        m_v, m_e;
    logic [31:0] m_r;
    int          m_idx;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        split_port_mem_if bus ();
        assign bus.i_req   = i_req[g];
        assign bus.i_addr  = i_addr[g];
        assign bus.d_req   = d_req[g];
        assign bus.d_we    = d_we[g];
        assign bus.d_be    = d_be[g];
        assign bus.d_addr  = d_addr[g];
        assign bus.d_wdata = d_wdata[g];
        assign i_ready[g]  = bus.i_ready;
        assign i_valid[g]  = bus.i_valid;
        assign i_rdata[g]  = bus.i_rdata;
        assign i_err[g]    = bus.i_err;
        assign d_ready[g]  = bus.d_ready;
        assign d_valid[g]  = bus.d_valid;
        assign d_rdata[g]  = bus.d_rdata;
        assign d_err[g]    = bus.d_err;
        split_port_mem #(
            .RD_LAT(LAT[g]), .PROTECT_INST(PROT[g]), .CLEAR_ON_RESET(CLR[g]), .INIT_FILE("")
        ) u_dut (
            .clk(clk), .rst(rst[g]), .bus(bus.slave)
        );
    end

    // Ports are numbered 2*u (fetch) and 2*u+1 (data) for instance u
    always @(negedge clk) begin
        if (mon_on) begin
            for (int p = 0; p < 6; p++) begin
                m_v = (p % 2 == 1) ? d_valid[p/2] : i_valid[p/2];
                m_e = (p % 2 == 1) ? d_err[p/2] : i_err[p/2];
                m_r = (p % 2 == 1) ? d_rdata[p/2] : i_rdata[p/2];
                checks++;
                if (m_v) begin
                    m_idx = -1;
                    foreach (sb[k]) if (m_idx < 0 && sb[k].port == p) m_idx = k;
                    if (m_idx < 0) begin
                        errors++;
                        $display("FAIL rsp port%0d: unexpected valid at cycle %0d rdata=%h err=%b", p, cyc, m_r, m_e);
                    end else begin
                        if (sb[m_idx].due != cyc || sb[m_idx].data !== m_r || sb[m_idx].err !== m_e) begin
                            errors++;
                            $display("FAIL rsp port%0d: got cycle %0d rdata=%h err=%b, expected cycle %0d rdata=%h err=%b",
                                     p, cyc, m_r, m_e, sb[m_idx].due, sb[m_idx].data, sb[m_idx].err);
                        end
                        sb.delete(m_idx);
                    end
                end else if (m_r !== 32'h0) begin
                    errors++;
                    $display("FAIL idle_rdata port%0d: got %h while valid=0, expected 0", p, m_r);
                end
            end
            for (int k = sb.size() - 1; k >= 0; k--) begin
                if (sb[k].due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing port%0d: no response at cycle %0d, expected rdata=%h err=%b",
                             sb[k].port, sb[k].due, sb[k].data, sb[k].err);
                    sb.delete(k);
                end
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic i_rd(int u, logic [31:0] a, logic [31:0] exp_d, logic exp_e);
        i_req[u] = 1'b1;
        i_addr[u] = a;
        sb.push_back('{2 * u, cyc + LAT[u], exp_d, exp_e});
    endtask

    task automatic d_req_set(int u, logic we, logic [3:0] be, logic [31:0] a, logic [31:0] w,
                             logic [31:0] exp_d, logic exp_e);
        d_req[u] = 1'b1;
        d_we[u] = we;
        d_be[u] = be;
        d_addr[u] = a;
        d_wdata[u] = w;
        sb.push_back('{2 * u + 1, cyc + LAT[u], exp_d, exp_e});
    endtask

    task automatic d_wr(int u, logic [3:0] be, logic [31:0] a, logic [31:0] w, logic exp_e);
        d_req_set(u, 1'b1, be, a, w, 32'h0, exp_e);
    endtask

    task automatic d_rd(int u, logic [31:0] a, logic [31:0] exp_d, logic exp_e);
        d_req_set(u, 1'b0, 4'h0, a, 32'h0, exp_d, exp_e);
    endtask

    task automatic step(int n = 1);
        repeat (n) begin
            @(negedge clk);
            i_req = '0;
            d_req = '0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] img0, img1;
        int n;
        img0 = 32'hCAFEF00D;
        img1 = 32'h0BADBEEF;
        rst = '1;
        i_req = '0;
        d_req = '0;
        d_we = '0;
        for (int u = 0; u < 3; u++) begin
            i_addr[u] = '0;
            d_addr[u] = '0;
            d_wdata[u] = '0;
            d_be[u] = '0;
        end
        // Protected fetch image of instance 0 cannot be written through its data port
        for (int k = 0; k < 4; k++) begin
            g_dut[0].u_dut.mem[32'h1000 + k] = img0[8*k +: 8];
            g_dut[0].u_dut.mem[32'h1004 + k] = img1[8*k +: 8];
        end
        repeat (3) @(negedge clk);
        rst = '0;
        @(negedge clk);
        check("rst_i_valid", 32'(i_valid), 32'h0);
        check("rst_d_valid", 32'(d_valid), 32'h0);
        check("rst_d_rdata0", d_rdata[0], 32'h0);
        check("rst_i_ready", 32'(i_ready), 32'h5);
        check("rst_d_ready", 32'(d_ready), 32'h5);
        mon_on = 1'b1;

        i_rd(0, 32'h1000, 32'hCAFEF00D, 1'b0); step();
        d_wr(0, 4'hF, 32'h10, 32'h11223344, 1'b0); step();
        d_wr(0, 4'b0101, 32'h10, 32'hAABBCCDD, 1'b0); step();
        d_rd(0, 32'h10, 32'h11BB33DD, 1'b0); step();
        d_wr(0, 4'h0, 32'h10, 32'hFFFFFFFF, 1'b0); step();
        d_rd(0, 32'h10, 32'h11BB33DD, 1'b0); step();
        d_rd(0, 32'h2, 32'h0, 1'b1); step();
        d_rd(0, 32'h2000, 32'h0, 1'b1); step();
        d_wr(0, 4'hF, 32'h1004, 32'hFFFFFFFF, 1'b1); step();
        i_rd(0, 32'h1004, 32'h0BADBEEF, 1'b0); step();
        d_wr(0, 4'hF, 32'hFFC, 32'h87654321, 1'b0); step();
        d_rd(0, 32'hFFC, 32'h87654321, 1'b0); i_rd(0, 32'hFFC, 32'h87654321, 1'b0); step();
        i_rd(0, 32'h1002, 32'h0, 1'b1); step();
        i_rd(0, 32'h2000, 32'h0, 1'b1); step(3);

        n = 0;
        while (!d_ready[1] && n < 2000) begin n++; @(negedge clk); end
        check("b_init_clear_done", 32'(d_ready[1]), 32'h1);
        d_wr(1, 4'hF, 32'h1000, 32'hCAFEF00D, 1'b0); step();
        i_rd(1, 32'h1000, 32'hCAFEF00D, 1'b0); step();
        i_rd(1, 32'h1000, 32'hCAFEF00D, 1'b0); d_rd(1, 32'h1000, 32'hCAFEF00D, 1'b0); step();
        d_wr(1, 4'hF, 32'h1008, 32'hA5A5A5A5, 1'b0); step();
        d_wr(1, 4'hF, 32'h1008, 32'h12345678, 1'b0); i_rd(1, 32'h1008, 32'hA5A5A5A5, 1'b0); step();
        i_rd(1, 32'h1008, 32'h12345678, 1'b0); step();
        d_wr(1, 4'hF, 32'h1FFC, 32'hDEADBEEF, 1'b0); step();
        d_rd(1, 32'h1FFC, 32'hDEADBEEF, 1'b0); i_rd(1, 32'h1FFE, 32'h0, 1'b1); step();
        d_rd(1, 32'h1FFD, 32'h0, 1'b1); i_rd(1, 32'h2000, 32'h0, 1'b1); step();
        d_rd(1, 32'h2000, 32'h0, 1'b1); step();
        d_wr(1, 4'hF, 32'hFFC, 32'h55AA55AA, 1'b0); step();
        d_rd(1, 32'hFFC, 32'h55AA55AA, 1'b0); step(5);

        // A second reset mid-clear must restart the walk from word 0
        rst[1] = 1'b1; step(); rst[1] = 1'b0;
        step(100);
        check("b_clear_busy", 32'(d_ready[1]), 32'h0);
        rst[1] = 1'b1; step(); rst[1] = 1'b0;
        n = 0;
        while (!d_ready[1] && n < 2000) begin n++; @(negedge clk); end
        check("b_clear_cycles", n, 32'd1024);
        check("b_i_ready_after_clear", 32'(i_ready[1]), 32'h1);
        d_rd(1, 32'hFFC, 32'h0, 1'b0); i_rd(1, 32'h1000, 32'hCAFEF00D, 1'b0); step();
        d_rd(1, 32'h0, 32'h0, 1'b0); i_rd(1, 32'h1FFC, 32'hDEADBEEF, 1'b0); step(5);

        d_wr(2, 4'hF, 32'h20, 32'h01020304, 1'b0); step(5);
        d_rd(2, 32'h20, 32'h01020304, 1'b0); step();
        d_rd(2, 32'h20, 32'h01020304, 1'b0); i_rd(2, 32'h20, 32'h01020304, 1'b0); step();
        d_rd(2, 32'h20, 32'h01020304, 1'b0); step();
        rst[2] = 1'b1;
        for (int k = sb.size() - 1; k >= 0; k--) if (sb[k].port >= 4) sb.delete(k);
        step();
        rst[2] = 1'b0;
        step(8);
        check("c_rst_d_valid", 32'(d_valid[2]), 32'h0);
        check("c_rst_i_ready", 32'(i_ready[2]), 32'h1);
        d_rd(2, 32'h20, 32'h01020304, 1'b0); i_rd(2, 32'h20, 32'h01020304, 1'b0); step(10);

        check("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
